// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian signal controller:
// direction indices, lightout group layout, lamp encodings and FSM states.
package ped_pkg;

    localparam int unsigned NUM_DIR = 4;
    localparam int unsigned LIGHT_W = 12;
    localparam int unsigned CD_W    = 8;

    localparam int unsigned DIR_N = 3;
    localparam int unsigned DIR_E = 2;
    localparam int unsigned DIR_S = 1;
    localparam int unsigned DIR_W = 0;

    localparam int unsigned OFF_N = 9;
    localparam int unsigned OFF_E = 6;
    localparam int unsigned OFF_S = 3;
    localparam int unsigned OFF_W = 0;

    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;

    typedef logic [1:0] dir_t;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        FLASH
    } state_e;

    // {green, yellow, red} group of one approach
    function automatic logic [2:0] light_grp(logic [LIGHT_W-1:0] lo, dir_t d);
        logic [2:0] g;
        case (d)
            dir_t'(DIR_N): g = lo[OFF_N +: 3];
            dir_t'(DIR_E): g = lo[OFF_E +: 3];
            dir_t'(DIR_S): g = lo[OFF_S +: 3];
            dir_t'(DIR_W): g = lo[OFF_W +: 3];
            default:       g = lo[OFF_W +: 3];
        endcase
        return g;
    endfunction

    // Every group one of G/Y/R and at most one green overall
    function automatic logic lights_valid(logic [LIGHT_W-1:0] lo);
        logic [2:0]  g;
        logic        ok;
        int unsigned n_green;
        ok      = 1'b1;
        n_green = 0;
        for (int i = 0; i < int'(NUM_DIR); i++) begin
            g = light_grp(lo, dir_t'(i));
            if (g != GREEN && g != YELLOW && g != RED) ok = 1'b0;
            if (g == GREEN) n_green = n_green + 1;
        end
        return ok && (n_green <= 1);
    endfunction

    function automatic logic [NUM_DIR-1:0] dir_mask(dir_t d);
        return NUM_DIR'(1) << d;
    endfunction

endpackage

// File: rtl/ped_signal_controller_if.sv
// Vehicle-light/push-button inputs and crosswalk lamp outputs of the controller.
interface ped_signal_controller_if;
    import ped_pkg::*;

    logic [LIGHT_W-1:0] lightout;
    logic [NUM_DIR-1:0] ped_req;
    logic [NUM_DIR-1:0] walk;
    logic [NUM_DIR-1:0] dont_walk;
    logic [CD_W-1:0]    countdown;
    logic [NUM_DIR-1:0] req_pending;
    logic               fault;

    modport master (
        output lightout, ped_req,
        input  walk, dont_walk, countdown, req_pending, fault
    );

    modport slave (
        input  lightout, ped_req,
        output walk, dont_walk, countdown, req_pending, fault
    );

endinterface

// File: rtl/ped_tick_gen.sv
// Free-running timing prescaler: tick is high while the count sits at TICK_DIV-1;
// restart forces the count back to 0 on the next edge.
module ped_tick_gen #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q + CW'(1);
        if (restart || cnt_q == CW'(TICK_DIV - 1)) cnt_nxt = '0;
    end

    // tick is registered from the next count so it lines up with cnt_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            tick  <= (cnt_nxt == CW'(TICK_DIV - 1));
        end
    end

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian WALK / flashing-clearance controller driven by the vehicle light vector.
// Optional build macro: PED_REQ_SYNC_EN adds a 2-flop synchronizer on ped_req.
module ped_signal_controller
    import ped_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 10,
    parameter int unsigned WALK_TICKS  = 6,
    parameter int unsigned FLASH_TICKS = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    ped_signal_controller_if.slave bus
);

    localparam int unsigned WCW = (WALK_TICKS > 1) ? $clog2(WALK_TICKS) : 1;

    state_e             state_q, state_nxt;
    dir_t               dir_q, dir_nxt;
    logic [WCW-1:0]     wcnt_q, wcnt_nxt;
    logic [CD_W-1:0]    cd_q, cd_nxt;
    logic [NUM_DIR-1:0] walk_q, walk_nxt;
    logic [NUM_DIR-1:0] dw_q, dw_nxt;
    logic [NUM_DIR-1:0] req_q, req_nxt;
    logic               fault_q, fault_nxt;
    logic [NUM_DIR-1:0] prev_green_q;

    logic [NUM_DIR-1:0] ped_s;
    logic [NUM_DIR-1:0] green_c, red_c, onset_c, serve_c;
    logic               valid_c;
    dir_t               sel_c;
    logic               restart_c;
    logic               tick;

`ifdef PED_REQ_SYNC_EN
    logic [NUM_DIR-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= bus.ped_req;
            sync_q2 <= sync_q1;
        end
    end

    assign ped_s = sync_q2;
`else
    assign ped_s = bus.ped_req;
`endif

    ped_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_c),
        .tick    (tick)
    );

    // Decode the light vector into per-direction green/red bits
    always_comb begin
        logic [2:0] grp;
        grp     = '0;
        green_c = '0;
        red_c   = '0;
        for (int i = 0; i < int'(NUM_DIR); i++) begin
            grp        = light_grp(bus.lightout, dir_t'(i));
            green_c[i] = grp[2];
            red_c[i]   = grp[0];
        end
        valid_c = lights_valid(bus.lightout);
        onset_c = green_c & ~prev_green_q;
    end

    // Next-state and lamp decisions; fault handling takes priority
    always_comb begin
        state_nxt = state_q;
        dir_nxt   = dir_q;
        wcnt_nxt  = wcnt_q;
        cd_nxt    = cd_q;
        walk_nxt  = walk_q;
        dw_nxt    = dw_q;
        fault_nxt = fault_q;
        restart_c = 1'b0;
        serve_c   = onset_c & (req_q | ped_s);
        sel_c     = '0;
        for (int i = 0; i < int'(NUM_DIR); i++) begin
            if (serve_c[i]) sel_c = dir_t'(i);
        end
        // a press on the crosswalk already walking is dropped
        req_nxt = req_q | (ped_s & ~((state_q == WALK) ? dir_mask(dir_q) : '0));

        if (!valid_c) begin
            fault_nxt = 1'b1;
            state_nxt = IDLE;
            walk_nxt  = '0;
            dw_nxt    = '1;
            cd_nxt    = '0;
        end else if (fault_q) begin
            // recovery edge: onsets seen here are not served
            fault_nxt = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|serve_c) begin
                        state_nxt = WALK;
                        dir_nxt   = sel_c;
                        wcnt_nxt  = '0;
                        walk_nxt  = dir_mask(sel_c);
                        dw_nxt    = ~dir_mask(sel_c);
                        restart_c = 1'b1;
                        req_nxt   = req_nxt & ~dir_mask(sel_c);
                    end
                end
                WALK: begin
                    if (!green_c[dir_q] || (tick && wcnt_q == WCW'(WALK_TICKS - 1))) begin
                        state_nxt = FLASH;
                        cd_nxt    = CD_W'(FLASH_TICKS);
                        walk_nxt  = '0;
                        dw_nxt    = '1;
                        restart_c = 1'b1;
                    end else if (tick) begin
                        wcnt_nxt = wcnt_q + WCW'(1);
                    end
                end
                FLASH: begin
                    if (red_c[dir_q] || (tick && cd_q == CD_W'(1))) begin
                        state_nxt = IDLE;
                        cd_nxt    = '0;
                        dw_nxt    = '1;
                    end else if (tick) begin
                        cd_nxt         = cd_q - CD_W'(1);
                        dw_nxt[dir_q]  = ~dw_q[dir_q];
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    walk_nxt  = '0;
                    dw_nxt    = '1;
                    cd_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dir_q        <= '0;
            wcnt_q       <= '0;
            cd_q         <= '0;
            walk_q       <= '0;
            dw_q         <= '1;
            req_q        <= '0;
            fault_q      <= 1'b0;
            prev_green_q <= '0;
        end else begin
            state_q      <= state_nxt;
            dir_q        <= dir_nxt;
            wcnt_q       <= wcnt_nxt;
            cd_q         <= cd_nxt;
            walk_q       <= walk_nxt;
            dw_q         <= dw_nxt;
            req_q        <= req_nxt;
            fault_q      <= fault_nxt;
            prev_green_q <= green_c;
        end
    end

    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dw_q;
    assign bus.countdown   = cd_q;
    assign bus.req_pending = req_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ped_signal_controller.sv
// Bench for ped_signal_controller: directed scenarios plus a random traffic sequence,
// every cycle compared against a time-based reference model.
module tb_ped_signal_controller;

    localparam int TD = 10;
    localparam int WT = 6;
    localparam int FT = 4;

    logic clk;
    logic rst_n;

    ped_signal_controller_if bus ();

    ped_signal_controller #(
        .TICK_DIV    (TD),
        .WALK_TICKS  (WT),
        .FLASH_TICKS (FT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_bad;

    // Reference model: phase + time of phase entry; lamps derive from elapsed cycles
    int         m_mode;     // 0 idle, 1 walk, 2 flash
    int         m_act;
    int         m_t0;
    int         m_n;
    logic [3:0] m_pend;
    logic [3:0] m_prev_g;
    logic       m_fault;
    logic [3:0] m_s1, m_s2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [11:0] pat(int gd, int col);
        logic [11:0] v;
        logic [2:0]  c;
        v = 12'h249;
        c = (col == 0) ? 3'b100 : (col == 1) ? 3'b010 : 3'b001;
        v[3*gd +: 3] = c;
        return v;
    endfunction

    function automatic bit lo_ok(logic [11:0] lo);
        int         greens;
        logic [2:0] g3;
        greens = 0;
        for (int d = 0; d < 4; d++) begin
            g3 = lo[3*d +: 3];
            if (!(g3 == 3'b100 || g3 == 3'b010 || g3 == 3'b001)) return 1'b0;
            if (g3 == 3'b100) greens++;
        end
        return greens <= 1;
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_act    = 0;
        m_t0     = 0;
        m_pend   = '0;
        m_prev_g = '0;
        m_fault  = 1'b0;
        m_s1     = '0;
        m_s2     = '0;
    endtask

    task automatic model_step(input logic [11:0] lo, input logic [3:0] pr);
        logic [3:0] eff, g, np, mask;
        logic [2:0] grp;
        bit         ok;
        m_n++;
`ifdef PED_REQ_SYNC_EN
        eff  = m_s2;
        m_s2 = m_s1;
        m_s1 = pr;
`else
        eff = pr;
`endif
        for (int d = 0; d < 4; d++) begin
            grp  = lo[3*d +: 3];
            g[d] = (grp == 3'b100);
        end
        ok   = lo_ok(lo);
        mask = (m_mode == 1) ? (4'b0001 << m_act) : 4'b0000;
        np   = m_pend | (eff & ~mask);
        if (!ok) begin
            m_fault = 1'b1;
            m_mode  = 0;
        end else if (m_fault) begin
            m_fault = 1'b0;
        end else if (m_mode == 0) begin
            for (int d = 0; d < 4; d++) begin
                if (g[d] && !m_prev_g[d] && (m_pend[d] || eff[d])) begin
                    m_mode = 1;
                    m_act  = d;
                    m_t0   = m_n;
                    np[d]  = 1'b0;
                end
            end
        end else if (m_mode == 1) begin
            if (!g[m_act] || (m_n - m_t0) == WT * TD) begin
                m_mode = 2;
                m_t0   = m_n;
            end
        end else begin
            grp = lo[3*m_act +: 3];
            if (grp == 3'b001 || (m_n - m_t0) == FT * TD) m_mode = 0;
        end
        m_prev_g = g;
        m_pend   = np;
    endtask

    task automatic compare_all();
        logic [3:0] ew, edw;
        logic [7:0] ecd;
        int         k;
        ew  = 4'h0;
        edw = 4'hF;
        ecd = 8'h00;
        if (m_mode == 1) begin
            ew  = 4'b0001 << m_act;
            edw = ~ew;
        end else if (m_mode == 2) begin
            k   = (m_n - m_t0) / TD;
            ecd = 8'(FT - k);
            if (k % 2 == 1) edw[m_act] = 1'b0;
        end
        check("walk",        32'(bus.walk),        32'(ew));
        check("dont_walk",   32'(bus.dont_walk),   32'(edw));
        check("countdown",   32'(bus.countdown),   32'(ecd));
        check("req_pending", 32'(bus.req_pending), 32'(m_pend));
        check("fault",       32'(bus.fault),       32'(m_fault));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(bus.lightout, bus.ped_req);
        #1;
        compare_all();
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic press(input logic [3:0] b);
        bus.ped_req = b;
        step();
        bus.ped_req = 4'h0;
        run(5);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_walk"},  32'(bus.walk),        32'h0);
        check({tag, "_dw"},    32'(bus.dont_walk),   32'hF);
        check({tag, "_cd"},    32'(bus.countdown),   32'h0);
        check({tag, "_req"},   32'(bus.req_pending), 32'h0);
        check({tag, "_fault"}, 32'(bus.fault),       32'h0);
    endtask

    int r_dir, r_ph, r_left;

    initial begin
        n_total      = 0;
        n_bad        = 0;
        m_n          = 0;
        rst_n        = 1'b0;
        bus.lightout = 12'h849;
        bus.ped_req  = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        run(20);
        check_reset_vals("idle_ng");

        // N request during SY, then NG: full walk and countdown
        bus.lightout = 12'h251;
        press(4'b1000);
        check("req_n_latched", 32'(bus.req_pending), 32'b1000);
        bus.lightout = 12'h849;
        step();
        check("ng_walk", 32'(bus.walk), 32'b1000);
        check("ng_dw",   32'(bus.dont_walk), 32'b0111);
        run(WT * TD - 1);
        check("walk_held", 32'(bus.walk), 32'b1000);
        step();
        check("flash_cd4", 32'(bus.countdown), 32'd4);
        check("flash_dw4", 32'(bus.dont_walk), 32'hF);
        run(TD);
        check("flash_cd3", 32'(bus.countdown), 32'd3);
        check("flash_dw3", 32'(bus.dont_walk), 32'b0111);
        run(3 * TD);
        check("flash_done_cd", 32'(bus.countdown), 32'd0);
        check("flash_done_req", 32'(bus.req_pending), 32'd0);
        bus.lightout = 12'h449; run(3);
        bus.lightout = 12'h249; run(3);

        // early FLASH entry on green drop
        press(4'b1000);
        bus.lightout = 12'h849; run(25);
        bus.lightout = 12'h449; step();
        check("early_cd", 32'(bus.countdown), 32'd4);
        check("early_walk", 32'(bus.walk), 32'd0);
        run(FT * TD);
        bus.lightout = 12'h249; run(3);

        // red cuts FLASH short
        press(4'b1000);
        bus.lightout = 12'h849; run(10);
        bus.lightout = 12'h449; run(5);
        bus.lightout = 12'h249; step();
        check("red_cut_cd", 32'(bus.countdown), 32'd0);
        run(3);

        // E and W together, N green serves nothing, W green serves W only
        bus.lightout = 12'h251;
        press(4'b0101);
        bus.lightout = 12'h849; step();
        check("ng_no_walk", 32'(bus.walk), 32'd0);
        run(5);
        bus.lightout = 12'h449; run(3);
        bus.lightout = 12'h249; run(2);
        bus.lightout = 12'h24C; step();
        check("wg_walk", 32'(bus.walk), 32'b0001);
        check("wg_req",  32'(bus.req_pending), 32'b0100);
        run(WT * TD + FT * TD);
        bus.lightout = 12'h249; run(3);

        // two greens mid-WALK forces fault
        press(4'b1000);
        bus.lightout = 12'h849; run(10);
        bus.lightout = 12'h9C9; step();
        check("fault_set",  32'(bus.fault), 32'd1);
        check("fault_walk", 32'(bus.walk), 32'd0);
        check("fault_dw",   32'(bus.dont_walk), 32'hF);
        run(2);
        bus.lightout = 12'h849; step();
        check("fault_clr", 32'(bus.fault), 32'd0);
        check("fault_req", 32'(bus.req_pending), 32'b0100);
        run(5);
        bus.lightout = 12'h249; run(3);

        // asynchronous reset in the middle of FLASH
        press(4'b0010);
        bus.lightout = pat(1, 0); run(WT * TD + 15);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.lightout = 12'h249;
        run(3);

        // randomized traffic sequence with button presses and glitches
        r_dir  = 0;
        r_ph   = 2;
        r_left = 2;
        for (int c = 0; c < 5000; c++) begin
            if (r_left == 0) begin
                if (r_ph == 0) begin
                    r_ph   = ($urandom_range(0, 9) == 0) ? 2 : 1;
                    r_left = (r_ph == 1) ? int'($urandom_range(3, 12)) : int'($urandom_range(1, 6));
                end else if (r_ph == 1) begin
                    r_ph   = 2;
                    r_left = $urandom_range(1, 6);
                end else begin
                    r_ph   = 0;
                    r_dir  = $urandom_range(0, 3);
                    r_left = $urandom_range(5, 110);
                end
            end
            r_left--;
            bus.lightout = (r_ph == 2) ? 12'h249 : pat(r_dir, r_ph);
            if ($urandom_range(0, 249) == 0) bus.lightout = 12'($urandom);
            for (int b = 0; b < 4; b++) bus.ped_req[b] = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ped_signal_controller.md
# ped_signal_controller

Pedestrian walk/don't-walk controller downstream of the four-way traffic light controller. It consumes the 12-bit `lightout` vehicle-light vector and per-direction pedestrian push-buttons. It grants a timed WALK interval parallel to the approach that has just turned green, followed by a flashing-don't-walk clearance with a countdown. Invalid vehicle-light patterns force every crosswalk to solid don't-walk.

## Interface
- `TICK_DIV`, 10 — clock cycles per timing tick (≥2).
- `WALK_TICKS`, 6 — WALK duration in ticks (≥1).
- `FLASH_TICKS`, 4 — flashing clearance duration in ticks (1..255).
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `lightout`  in  12  — vehicle lights, N[11:9] E[8:6] S[5:3] W[2:0]; each group is {green, yellow, red}.
- `ped_req`  in  4  — push-buttons, bit3=N, bit2=E, bit1=S, bit0=W (same order for all 4-bit ports).
- `walk`  out  4  — WALK lamp per crosswalk.
- `dont_walk`  out  4  — DON'T-WALK lamp per crosswalk.
- `countdown`  out  8  — remaining clearance ticks; 0 outside FLASH.
- `req_pending`  out  4  — latched, unserved requests.
- `fault`  out  1  — invalid `lightout` detected.

## Operation
- **Reset values:** `walk`=0, `dont_walk`=4'hF, `countdown`=0, `req_pending`=0, `fault`=0, state IDLE, `prev_green`=0, prescaler=0.
- **Green onset for direction d:**
  - Condition: green bit of d is 1 in `lightout` and 0 in `prev_green` (registered copy of the 4 green bits).
  - `prev_green` updates every cycle.
- **Request latch:**
  - `req_pending[d]` sets on any cycle where sampled `ped_req[d]`=1.
  - It clears on the edge where WALK starts for d.
  - A request for the direction currently in WALK is ignored.
  - A request during that direction's FLASH is latched for its next green.
- **FSM states:**
  - IDLE → WALK(d): green onset for d and (`req_pending[d]` or sampled `ped_req[d]`) on the same edge. Record d, set `walk[d]`=1, `dont_walk[d]`=0, restart the prescaler.
  - WALK → FLASH: after `WALK_TICKS` ticks. Load `countdown`=`FLASH_TICKS`, `walk[d]`=0, `dont_walk[d]`=1.
  - WALK → FLASH early: green bit of d drops while in WALK. Same FLASH entry actions, prescaler restarted.
  - In FLASH, every tick: `dont_walk[d]` toggles and `countdown` decrements.
  - FLASH → IDLE: on the tick where `countdown`==1. Result is `countdown`=0, `dont_walk[d]`=1.
  - FLASH → IDLE immediately: d's red bit asserts. Result is solid don't-walk, `countdown`=0.
- **Fault:**
  - Invalid `lightout` means any group not in {100, 010, 001}, or more than one green.
  - On the next edge: `fault`=1, state IDLE, `walk`=0, `dont_walk`=4'hF, `countdown`=0.
  - `req_pending` is retained.
  - `fault` clears on the first edge with valid `lightout`.
  - Onsets are not accepted on the edge where `fault` clears.
- Crosswalks other than the active d always show `dont_walk`=1.

## Timing
- **Tick:** the prescaler counts 0..`TICK_DIV`-1 and pulses a tick at `TICK_DIV`-1. It is free-running and restarted to 0 on WALK and FLASH entry.
- **WALK length:** exactly `WALK_TICKS`×`TICK_DIV` cycles.
- **FLASH length:** exactly `FLASH_TICKS`×`TICK_DIV` cycles.
- **Latency:**
  - `lightout` change → `walk` asserted on the following edge (1 cycle).
  - `ped_req` → `req_pending`: 1 cycle (3 with sync enabled).
- **Simultaneous events:**
  - Request and onset on the same edge are served.
  - Green drop and WALK expiry on the same edge give a single FLASH entry.
  - Fault overrides all other transitions.
- **Reset mid-operation:** all outputs return to reset values asynchronously. A pending walk is lost.

## Configuration
- `PED_REQ_SYNC_EN` defined: `ped_req` passes through a 2-flop synchronizer (reset to 0) before use, adding 2 cycles of request latency.
- Not defined: `ped_req` is sampled directly; the caller guarantees it is synchronous to `clk`.

## Structure
- **Package `ped_pkg`:**
  - Direction indices: N=3, E=2, S=1, W=0.
  - `lightout` group slice offsets (N=9, E=6, S=3, W=0).
  - Light encodings GREEN=3'b100, YELLOW=3'b010, RED=3'b001.
  - FSM state enum {IDLE, WALK, FLASH}.
- **Sub-module `ped_tick_gen`:** prescaler with synchronous restart input and `tick` output.

## Test plan
- Reset with `lightout`=NG pattern 12'h849, no requests → `walk`=0, `dont_walk`=F, `countdown`=0 indefinitely.
- Pulse `ped_req[3]` during SY, then apply NG → `walk`=4'b1000 one cycle after NG, held 60 cycles. Then FLASH with `countdown` 4,3,2,1 every 10 cycles and `dont_walk[3]` toggling. Then IDLE, `req_pending[3]`=0.
- Request N, apply NG, switch to NY after 25 cycles → early FLASH entry on next edge, full 40-cycle clearance unless red asserts first.
- Request E and W together during SY, then apply NG → no walk. Then WG → `walk[0]` only, `req_pending`=4'b0100 remains.
- Apply 12'h9C9 (two greens) mid-WALK → `fault`=1 next edge, `walk`=0, `dont_walk`=F. Restore valid pattern → `fault`=0, `req_pending` intact.
- Assert `rst_n`=0 mid-FLASH → all outputs to reset values immediately.
